// File: rtl/controle_timeout.sv
// controle_timeout: session timeout controller driving a modulo-M counter through zera_s/conta
module controle_timeout #(
  parameter int LIMITE = 3,
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         jogada,
  input  logic         pausa,
  input  logic         cancela,
  input  logic         fim,
  input  logic         meio,
  output logic         zera_s,
  output logic         conta,
  output logic         ativo,
  output logic         alerta,
  output logic         timeout,
  output logic         esgotado,
  output logic [W-1:0] estouros,
  output logic [2:0]   db_estado
);
  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    PREPARA  = 3'd1,
    CONTANDO = 3'd2,
    PAUSADO  = 3'd3,
    ESTOUROU = 3'd4,
    ESGOTADO = 3'd5
  } estado_t;
  estado_t estado, prox;
  logic visto, visto_prox;
  logic [W-1:0] est_prox;
  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL:  prox = iniciar ? PREPARA : INICIAL;
      PREPARA:  prox = CONTANDO;
      CONTANDO: prox = cancela ? INICIAL : jogada ? PREPARA : fim ? ESTOUROU : pausa ? PAUSADO : CONTANDO;
      PAUSADO:  prox = cancela ? INICIAL : jogada ? PREPARA : pausa ? PAUSADO : CONTANDO;
      ESTOUROU: prox = (estouros == W'(LIMITE)) ? ESGOTADO : PREPARA;
      ESGOTADO: prox = cancela ? INICIAL : iniciar ? PREPARA : ESGOTADO;
      default:  prox = INICIAL;
    endcase
    est_prox = ((estado == INICIAL || estado == ESGOTADO) && prox == PREPARA) ? '0 :
               (estado == CONTANDO && prox == ESTOUROU && !(&estouros)) ? estouros + 1'b1 : estouros;
    visto_prox = (prox == INICIAL || prox == PREPARA) ? 1'b0 : visto | (estado == CONTANDO && meio);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      estouros <= '0;
      visto    <= 1'b0;
    end else begin
      estado   <= prox;
      estouros <= est_prox;
      visto    <= visto_prox;
    end
  end
  assign zera_s    = !(estado == CONTANDO || estado == PAUSADO);
  assign conta     = estado == CONTANDO;
  assign ativo     = estado == PREPARA || estado == CONTANDO || estado == PAUSADO;
  assign alerta    = ativo && visto;
  assign timeout   = estado == ESTOUROU;
  assign esgotado  = estado == ESGOTADO;
  assign db_estado = estado;
endmodule

// File: tb/tb_controle_timeout.sv
// tb_controle_timeout: self-checking bench pairing the controller with a modulo-10 counter
module tb_controle_timeout;
  logic clock = 1'b0, reset = 1'b0, iniciar = 1'b0, jogada = 1'b0, pausa = 1'b0, cancela = 1'b0;
  logic fim, meio, zera_s, conta, ativo, alerta, timeout, esgotado;
  logic [1:0] estouros;
  logic [2:0] db_estado;
  logic [3:0] cnt;
  int errors = 0, checks = 0;
  int m_s = 0, m_e = 0, m_f = 0, m_c = 0;
  controle_timeout #(.LIMITE(3), .W(2)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .pausa(pausa),
    .cancela(cancela), .fim(fim), .meio(meio), .zera_s(zera_s), .conta(conta),
    .ativo(ativo), .alerta(alerta), .timeout(timeout), .esgotado(esgotado),
    .estouros(estouros), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (reset || zera_s) cnt <= 4'd0;
    else if (conta) cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
  end
  assign fim = cnt == 4'd9;
  assign meio = cnt == 4'd4;
  function automatic logic [10:0] obs();
    return {zera_s, conta, ativo, alerta, timeout, esgotado, estouros, db_estado};
  endfunction
  function automatic logic [10:0] mk(int st, int est, bit alr);
    logic [1:0] e2 = 2'(est);
    logic [2:0] s3 = 3'(st);
    return {st != 2 && st != 3, st == 2, st >= 1 && st <= 3, alr, st == 4, st == 5, e2, s3};
  endfunction
  task automatic model_step();
    int ns, ne, nf, nc;
    if (reset) begin
      m_s = 0; m_e = 0; m_f = 0; m_c = 0;
    end else begin
      nc = (m_s == 2) ? (m_c + 1) % 10 : (m_s == 3) ? m_c : 0;
      ne = m_e;
      ns = 0;
      if (m_s == 0) begin
        ns = iniciar ? 1 : 0;
        if (iniciar) ne = 0;
      end else if (m_s == 1) ns = 2;
      else if (m_s == 2) begin
        ns = cancela ? 0 : jogada ? 1 : (m_c == 9) ? 4 : pausa ? 3 : 2;
        if (ns == 4) ne = (m_e < 3) ? m_e + 1 : 3;
      end else if (m_s == 3) ns = cancela ? 0 : jogada ? 1 : pausa ? 3 : 2;
      else if (m_s == 4) ns = (m_e == 3) ? 5 : 1;
      else if (m_s == 5) begin
        ns = cancela ? 0 : iniciar ? 1 : 5;
        if (!cancela && iniciar) ne = 0;
      end
      nf = (ns <= 1) ? 0 : (m_s == 2 && m_c == 4) ? 1 : m_f;
      m_s = ns; m_e = ne; m_f = nf; m_c = nc;
    end
  endtask
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask
  task automatic do_reset();
    {iniciar, jogada, pausa, cancela} = 4'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic start_session();
    do_reset();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== mk(0, 0, 0)) begin
      errors++;
      $display("FAIL reset got=%b exp=%b", obs(), mk(0, 0, 0));
    end
  endtask
  task automatic test_basic();
    int st;
    start_session();
    for (int c = 1; c <= 13; c++) begin
      st = (c == 1 || c == 13) ? 1 : (c == 12) ? 4 : 2;
      checks++;
      if (obs() !== mk(st, c >= 12, c >= 7 && c <= 11)) begin
        errors++;
        $display("FAIL basic c=%0d got=%b exp=%b", c, obs(), mk(st, c >= 12, c >= 7 && c <= 11));
      end
      if (c >= 2 && c <= 11) begin
        checks++;
        if (cnt !== 4'(c - 2)) begin
          errors++;
          $display("FAIL basic_cnt c=%0d got=%0d exp=%0d", c, cnt, c - 2);
        end
      end
      tick();
    end
  endtask
  task automatic test_jogada();
    start_session();
    repeat (8) tick();
    checks++;
    if (cnt !== 4'd7) begin errors++; $display("FAIL jog_pre got=%0d exp=7", cnt); end
    jogada = 1'b1; tick(); jogada = 1'b0;
    checks++;
    if (obs() !== mk(1, 0, 1'b0)) begin errors++; $display("FAIL jog_prep got=%b exp=%b", obs(), mk(1, 0, 0)); end
    tick();
    checks++;
    if (db_estado !== 3'd2 || cnt !== 4'd0) begin errors++; $display("FAIL jog_restart got=%0d/%0d exp=2/0", db_estado, cnt); end
    repeat (9) tick();
    checks++;
    if (fim !== 1'b1) begin errors++; $display("FAIL jog_fim got=%b exp=1", fim); end
    jogada = 1'b1; tick(); jogada = 1'b0;
    checks++;
    if (obs() !== mk(1, 0, 1'b0)) begin errors++; $display("FAIL jog_fim_win got=%b exp=%b", obs(), mk(1, 0, 0)); end
    tick();
    checks++;
    if (db_estado !== 3'd2 || cnt !== 4'd0 || estouros !== 2'd0) begin
      errors++; $display("FAIL jog_fim_after got=%0d/%0d/%0d exp=2/0/0", db_estado, cnt, estouros);
    end
  endtask
  task automatic test_pausa();
    int t;
    start_session();
    repeat (3) tick();
    pausa = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) pausa = 1'b0;
      checks++;
      if (db_estado !== 3'd3 || cnt !== 4'd3 || conta !== 1'b0 || zera_s !== 1'b0) begin
        errors++; $display("FAIL pause_hold i=%0d got=%0d/%0d exp=3/3", i, db_estado, cnt);
      end
    end
    tick();
    checks++;
    if (db_estado !== 3'd2 || cnt !== 4'd3) begin errors++; $display("FAIL pause_resume got=%0d/%0d exp=2/3", db_estado, cnt); end
    t = 10;
    while (!timeout && t < 40) begin tick(); t++; end
    checks++;
    if (t != 17) begin errors++; $display("FAIL pause_delay got=%0d exp=17", t); end
    start_session();
    repeat (10) tick();
    pausa = 1'b1; tick(); pausa = 1'b0;
    checks++;
    if (db_estado !== 3'd4 || timeout !== 1'b1 || estouros !== 2'd1) begin
      errors++; $display("FAIL fim_pausa got=%0d/%b/%0d exp=4/1/1", db_estado, timeout, estouros);
    end
  endtask
  task automatic test_esgota();
    int pulses[$];
    int ests[$];
    int c = 1;
    start_session();
    while (!esgotado && c < 60) begin
      if (timeout) begin pulses.push_back(c); ests.push_back(int'(estouros)); end
      tick();
      c++;
    end
    checks++;
    if (c != 37 || pulses.size() != 3) begin errors++; $display("FAIL esg_when got=%0d/%0d exp=37/3", c, pulses.size()); end
    foreach (pulses[i]) begin
      checks++;
      if (pulses[i] != 12 * (i + 1) || ests[i] != i + 1) begin
        errors++; $display("FAIL esg_pulse%0d got=%0d/%0d exp=%0d/%0d", i, pulses[i], ests[i], 12 * (i + 1), i + 1);
      end
    end
    jogada = 1'b1; tick(); jogada = 1'b0;
    checks++;
    if (obs() !== mk(5, 3, 0)) begin errors++; $display("FAIL esg_jogada got=%b exp=%b", obs(), mk(5, 3, 0)); end
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    checks++;
    if (obs() !== mk(1, 0, 0)) begin errors++; $display("FAIL esg_iniciar got=%b exp=%b", obs(), mk(1, 0, 0)); end
  endtask
  task automatic test_reset_cancel();
    start_session();
    repeat (7) tick();
    checks++;
    if (cnt !== 4'd6) begin errors++; $display("FAIL rst_pre got=%0d exp=6", cnt); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (obs() !== mk(0, 0, 0) || cnt !== 4'd0) begin errors++; $display("FAIL rst_mid got=%b/%0d exp=%b/0", obs(), cnt, mk(0, 0, 0)); end
    start_session();
    repeat (10) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (obs() !== mk(0, 0, 0)) begin errors++; $display("FAIL rst_fim got=%b exp=%b", obs(), mk(0, 0, 0)); end
    start_session();
    repeat (3) tick();
    pausa = 1'b1; tick();
    cancela = 1'b1; tick(); cancela = 1'b0; pausa = 1'b0;
    checks++;
    if (obs() !== mk(0, 0, 0)) begin errors++; $display("FAIL cancel_pause got=%b exp=%b", obs(), mk(0, 0, 0)); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      iniciar = ($urandom_range(7) == 0);
      jogada  = ($urandom_range(15) == 0);
      pausa   = ($urandom_range(3) == 0);
      cancela = ($urandom_range(59) == 0);
      reset   = ($urandom_range(299) == 0);
      tick();
      checks++;
      if (obs() !== mk(m_s, m_e, m_s >= 1 && m_s <= 3 && m_f != 0) || cnt !== 4'(m_c)) begin
        errors++;
        $display("FAIL random i=%0d got=%b/%0d exp=%b/%0d", i, obs(), cnt, mk(m_s, m_e, m_s >= 1 && m_s <= 3 && m_f != 0), m_c);
      end
    end
    reset = 1'b0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_jogada();
    test_pausa();
    test_esgota();
    test_reset_cancel();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
